// File: rtl/ps2_digit_pkg.sv
// Scan-code constants and digit decode shared by the event queue and the game FSM.
// Keypad digits are decoded only when KEYPAD_DIGITS_EN is defined.
package ps2_digit_pkg;

   localparam logic [8:0] SC_MAIN_0 = 9'h045;
   localparam logic [8:0] SC_MAIN_1 = 9'h016;
   localparam logic [8:0] SC_MAIN_2 = 9'h01E;
   localparam logic [8:0] SC_MAIN_3 = 9'h026;
   localparam logic [8:0] SC_MAIN_4 = 9'h025;
   localparam logic [8:0] SC_MAIN_5 = 9'h02E;
   localparam logic [8:0] SC_MAIN_6 = 9'h036;
   localparam logic [8:0] SC_MAIN_7 = 9'h03D;
   localparam logic [8:0] SC_MAIN_8 = 9'h03E;
   localparam logic [8:0] SC_MAIN_9 = 9'h046;

   localparam logic [8:0] SC_KP_0 = 9'h070;
   localparam logic [8:0] SC_KP_1 = 9'h069;
   localparam logic [8:0] SC_KP_2 = 9'h072;
   localparam logic [8:0] SC_KP_3 = 9'h07A;
   localparam logic [8:0] SC_KP_4 = 9'h06B;
   localparam logic [8:0] SC_KP_5 = 9'h073;
   localparam logic [8:0] SC_KP_6 = 9'h074;
   localparam logic [8:0] SC_KP_7 = 9'h06C;
   localparam logic [8:0] SC_KP_8 = 9'h075;
   localparam logic [8:0] SC_KP_9 = 9'h07D;

   localparam logic [3:0] DIGIT_NONE = 4'hF;

`ifdef KEYPAD_DIGITS_EN
   localparam int HELD_W = 20;
`else
   localparam int HELD_W = 10;
`endif

   // Held-map slot: main-row digit d uses bit d, keypad digit d uses bit 10+d.
   function automatic logic [4:0] code_to_slot(input logic [8:0] code);
      logic [4:0] slot;
      slot = 5'd31;
      case (code)
         SC_MAIN_0: slot = 5'd0;
         SC_MAIN_1: slot = 5'd1;
         SC_MAIN_2: slot = 5'd2;
         SC_MAIN_3: slot = 5'd3;
         SC_MAIN_4: slot = 5'd4;
         SC_MAIN_5: slot = 5'd5;
         SC_MAIN_6: slot = 5'd6;
         SC_MAIN_7: slot = 5'd7;
         SC_MAIN_8: slot = 5'd8;
         SC_MAIN_9: slot = 5'd9;
`ifdef KEYPAD_DIGITS_EN
         SC_KP_0:   slot = 5'd10;
         SC_KP_1:   slot = 5'd11;
         SC_KP_2:   slot = 5'd12;
         SC_KP_3:   slot = 5'd13;
         SC_KP_4:   slot = 5'd14;
         SC_KP_5:   slot = 5'd15;
         SC_KP_6:   slot = 5'd16;
         SC_KP_7:   slot = 5'd17;
         SC_KP_8:   slot = 5'd18;
         SC_KP_9:   slot = 5'd19;
`endif
         default:   slot = 5'd31;
      endcase
      return slot;
   endfunction

   function automatic logic [3:0] code_to_digit(input logic [8:0] code);
      logic [4:0] slot;
      slot = code_to_slot(code);
      if (slot == 5'd31)
         return DIGIT_NONE;
      else if (slot >= 5'd10)
         return 4'(slot - 5'd10);
      else
         return slot[3:0];
   endfunction

   function automatic logic [HELD_W-1:0] code_to_held_mask(input logic [8:0] code);
      logic [4:0] slot;
      slot = code_to_slot(code);
      if (slot == 5'd31)
         return '0;
      else
         return HELD_W'(1) << slot;
   endfunction

endpackage

// File: rtl/digit_fifo.sv
// DEPTH x 4 show-ahead FIFO; flush dominates push/pop, full push accepted only with a same-cycle pop.
module digit_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [3:0]                 push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [3:0]                 head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [3:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == FULL_CNT);
   assign pop_ok  = pop_i && (count_q != '0);
   assign push_ok = push_i && (!full_o || pop_ok);
   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= push_data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_ok) rd_q <= rd_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ps2_digit_event_queue.sv
// Turns PS/2 make/break events into one queued digit per physical press, dropping typematic repeats.
// Define KEYPAD_DIGITS_EN to also accept keypad digits with their own held bits.
module ps2_digit_event_queue
   import ps2_digit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int OVF_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_valid,
   input  logic [8:0]             last_change,
   input  logic                   key_make,
   input  logic                   flush,
   output logic                   out_valid,
   output logic [3:0]             out_digit,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic [OVF_W-1:0]       ovf_cnt
);

   logic [HELD_W-1:0] held_q, held_d, key_mask;
   logic [3:0]        key_digit;
   logic              push_req, pop, fifo_full, drop;
   logic [OVF_W-1:0]  ovf_q, ovf_d;

   assign key_mask  = code_to_held_mask(last_change);
   assign key_digit = code_to_digit(last_change);
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign ovf_cnt   = ovf_q;

   // A make only counts as a press when its held bit was clear; repeats set nothing new.
   always_comb begin
      held_d   = held_q;
      push_req = 1'b0;
      if (key_valid && (key_mask != '0)) begin
         if (key_make) begin
            if ((held_q & key_mask) == '0) push_req = 1'b1;
            held_d = held_q | key_mask;
         end else begin
            held_d = held_q & ~key_mask;
         end
      end
   end

   always_comb begin
      drop  = push_req && fifo_full && !pop;
      ovf_d = ovf_q;
      if (drop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_q <= '0;
         ovf_q  <= '0;
      end else begin
         held_q <= held_d;
         ovf_q  <= ovf_d;
      end
   end

   digit_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_req),
      .push_data_i (key_digit),
      .pop_i       (pop),
      .flush_i     (flush),
      .head_o      (out_digit),
      .count_o     (count),
      .full_o      (fifo_full)
   );

endmodule

// File: tb/tb_ps2_digit_event_queue.sv
// Directed bench for ps2_digit_event_queue with a press model and expected-digit queue.
module tb_ps2_digit_event_queue;

   localparam int DEPTH   = 4;
   localparam int OVF_W   = 8;
   localparam int OVF_MAX = (1 << OVF_W) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [8:0] last_change = '0;
   logic       key_make = 1'b0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [3:0] out_digit;
   logic [$clog2(DEPTH):0] count;
   logic [OVF_W-1:0]       ovf_cnt;

   logic [3:0] exp_q[$];
   bit [511:0] held_m;
   int         exp_ovf;
   int         n_checks = 0;
   int         n_errors = 0;

   ps2_digit_event_queue #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .last_change (last_change),
      .key_make    (key_make),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_digit   (out_digit),
      .out_ready   (out_ready),
      .count       (count),
      .ovf_cnt     (ovf_cnt)
   );

   always #5 clk = ~clk;

   function automatic int tb_digit(input logic [8:0] code);
      case (code)
         9'h045: return 0;  9'h016: return 1;  9'h01E: return 2;  9'h026: return 3;
         9'h025: return 4;  9'h02E: return 5;  9'h036: return 6;  9'h03D: return 7;
         9'h03E: return 8;  9'h046: return 9;
`ifdef KEYPAD_DIGITS_EN
         9'h070: return 0;  9'h069: return 1;  9'h072: return 2;  9'h07A: return 3;
         9'h06B: return 4;  9'h073: return 5;  9'h074: return 6;  9'h06C: return 7;
         9'h075: return 8;  9'h07D: return 9;
`endif
         default: return -1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
      check({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
      check({tag, "_ovf"}, 32'(ovf_cnt), 32'(exp_ovf));
      if (exp_q.size() != 0) check({tag, "_digit"}, 32'(out_digit), 32'(exp_q[0]));
   endtask

   // One decoder event; optionally pops the head and/or flushes in the same cycle.
   task automatic send_key(input logic [8:0] code, input bit make, input bit pop_now, input bit flush_now);
      int  d;
      bit  req;
      bit  full_m;
      @(negedge clk);
      last_change = code;
      key_make    = make;
      key_valid   = 1'b1;
      out_ready   = pop_now;
      flush       = flush_now;
      if (pop_now) begin
         check("pop_head_valid", 32'(out_valid), 32'd1);
         check("pop_head_digit", 32'(out_digit), 32'(exp_q[0]));
      end
      d   = tb_digit(code);
      req = 1'b0;
      if (d >= 0) begin
         if (make) begin
            if (!held_m[code]) req = 1'b1;
            held_m[code] = 1'b1;
         end else begin
            held_m[code] = 1'b0;
         end
      end
      full_m = (exp_q.size() == DEPTH);
      if (req && full_m && !pop_now) begin
         if (exp_ovf != OVF_MAX) exp_ovf++;
         req = 1'b0;
      end
      if (flush_now) exp_q.delete();
      else begin
         if (pop_now) void'(exp_q.pop_front());
         if (req) exp_q.push_back(4'(d));
      end
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic press(input logic [8:0] code);
      send_key(code, 1'b1, 1'b0, 1'b0);
      send_key(code, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_one(input string tag);
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_digit"}, 32'(out_digit), 32'(exp_q[0]));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      void'(exp_q.pop_front());
   endtask

   initial begin
      held_m  = '0;
      exp_ovf = 0;

      // Reset values, checked before any clock edge.
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_digit", 32'(out_digit), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ovf", 32'(ovf_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single press of main 7, one-cycle latency.
      check_state("pre7");
      send_key(9'h03D, 1'b1, 1'b0, 1'b0);
      check_state("post7");
      check("digit7", 32'(out_digit), 32'd7);
      send_key(9'h03D, 1'b0, 1'b0, 1'b0);
      pop_one("pop7");
      check_state("empty7");

      // Typematic repeats of 1 collapse to one entry.
      repeat (3) send_key(9'h016, 1'b1, 1'b0, 1'b0);
      send_key(9'h016, 1'b0, 1'b0, 1'b0);
      check_state("rep1");
      send_key(9'h016, 1'b1, 1'b0, 1'b0);
      send_key(9'h016, 1'b0, 1'b0, 1'b0);
      check_state("rep1b");
      pop_one("pop1a");
      pop_one("pop1b");

      // Non-digit and extended codes are ignored.
      press(9'h01C);
      press(9'h145);
      check_state("nondigit");

      // Overflow: five presses into a DEPTH-4 FIFO.
      press(9'h045); press(9'h016); press(9'h01E); press(9'h026); press(9'h025);
      check_state("full");
      check("ovf_one", 32'(ovf_cnt), 32'd1);
      repeat (4) pop_one("drain");
      check_state("drained");

      // Full FIFO with a same-cycle push and pop.
      press(9'h045); press(9'h016); press(9'h01E); press(9'h026);
      send_key(9'h025, 1'b1, 1'b1, 1'b0);
      check_state("pushpop_full");
      send_key(9'h025, 1'b0, 1'b0, 1'b0);
      repeat (4) pop_one("pp_drain");
      check_state("pp_empty");

      // Keypad 8 then extended E0-75.
      press(9'h075);
      press(9'h175);
      check_state("keypad");
      if (exp_q.size() != 0) pop_one("kp_pop");

      // Flush beats a same-cycle push; held map survives the flush.
      press(9'h036); press(9'h03E);
      send_key(9'h046, 1'b1, 1'b0, 1'b1);
      check_state("flush");
      send_key(9'h046, 1'b1, 1'b0, 1'b0);
      check_state("flush_held");
      send_key(9'h046, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset while 2 is held and three entries are queued.
      press(9'h045); press(9'h016);
      send_key(9'h01E, 1'b1, 1'b0, 1'b0);
      check_state("pre_rst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.delete();
      held_m  = '0;
      exp_ovf = 0;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_digit", 32'(out_digit), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      check("arst_ovf", 32'(ovf_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_key(9'h01E, 1'b1, 1'b0, 1'b0);
      check_state("after_rst");
      check("after_rst_digit", 32'(out_digit), 32'd2);
      pop_one("pop2");
      send_key(9'h01E, 1'b0, 1'b0, 1'b0);

      // Overflow counter saturation.
      press(9'h045); press(9'h016); press(9'h026); press(9'h025);
      for (int i = 0; i < OVF_MAX + 5; i++) press(9'h03D);
      check_state("ovf_sat");
      send_key(9'h000, 1'b0, 1'b0, 1'b1);
      check_state("final_flush");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
